// File: rtl/core_pkg.sv
// Shared types for the memory-port arbiter: access widths and arbiter FSM states.
package core_pkg;

   typedef enum logic [1:0] {
      DW_BYTE = 2'b00,
      DW_HALF = 2'b01,
      DW_WORD = 2'b10
   } dw_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      REQ_IF  = 2'b01,
      REQ_LSU = 2'b10,
      DRAIN   = 2'b11
   } arb_state_t;

endpackage

// File: rtl/lsu_store_align.sv
// Byte-lane strobes, lane-replicated store data and misalignment detection
// for a single LSU access.
module lsu_store_align
   import core_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  dw_e         width,
   input  logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_al,
   output logic        misalign
);

   always_comb begin
      wstrb    = 4'b0000;
      wdata_al = 32'h0;
      misalign = 1'b0;
      case (width)
         DW_BYTE: begin
            wstrb    = 4'b0001 << addr_lo;
            wdata_al = {4{wdata[7:0]}};
         end
         DW_HALF: begin
            wstrb    = 4'b0011 << addr_lo;
            wdata_al = {2{wdata[15:0]}};
            misalign = addr_lo[0];
         end
         DW_WORD: begin
            wstrb    = 4'b1111;
            wdata_al = wdata;
            misalign = |addr_lo;
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one
// transaction outstanding, with starvation bound and response timeout.
//
// state   | meaning
// IDLE    | no bus transaction; arbitrate, or answer a misaligned LSU access
// REQ_IF  | fetch on the bus, waiting for mem_rvalid
// REQ_LSU | load/store on the bus, waiting for mem_rvalid
// DRAIN   | fetch flushed; bus request held until mem_rvalid, response dropped
module mem_port_arbiter
   import core_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        lsu_req,
   input  logic        lsu_we,
   input  logic [31:0] lsu_addr,
   input  logic [1:0]  lsu_width,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   arb_state_t  state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic        if_done_q, if_done_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        lsu_done_q, lsu_done_d;
   logic [31:0] lsu_rdata_q, lsu_rdata_d;
   logic        lsu_err_q, lsu_err_d;

   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata;
   logic        al_misalign;
   logic        if_live, if_forced, lsu_win, if_win, tmo_tc;

   lsu_store_align u_align (
      .addr_lo  (lsu_addr[1:0]),
      .width    (dw_e'(lsu_width)),
      .wdata    (lsu_wdata),
      .wstrb    (al_wstrb),
      .wdata_al (al_wdata),
      .misalign (al_misalign)
   );

   // LSU is older and wins by default; a starved fetch is forced through.
   assign if_live   = if_req && !if_flush;
   assign if_forced = if_live && (starve_q == SW'(STARVE_LIMIT));
   assign lsu_win   = lsu_req && !if_forced;
   assign if_win    = if_live && !lsu_win;
   assign tmo_tc    = (tmo_q == '0);

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      if_done_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      lsu_done_d  = 1'b0;
      lsu_rdata_d = lsu_rdata_q;
      lsu_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!if_req || if_win)
               starve_d = '0;
            else if (if_live && lsu_win && starve_q != SW'(STARVE_LIMIT))
               starve_d = starve_q + SW'(1);

            if (lsu_win) begin
               if (al_misalign) begin
                  lsu_done_d  = 1'b1;
                  lsu_err_d   = 1'b1;
                  lsu_rdata_d = 32'h0;
               end else begin
                  state_d     = REQ_LSU;
                  mem_req_d   = 1'b1;
                  mem_we_d    = lsu_we;
                  mem_addr_d  = lsu_addr & 32'hFFFF_FFFC;
                  mem_wdata_d = lsu_we ? al_wdata : 32'h0;
                  mem_wstrb_d = lsu_we ? al_wstrb : 4'b0000;
                  tmo_d       = TW'(TIMEOUT - 1);
               end
            end else if (if_win) begin
               state_d     = REQ_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr & 32'hFFFF_FFFC;
               mem_wdata_d = 32'h0;
               mem_wstrb_d = 4'b0000;
               tmo_d       = TW'(TIMEOUT - 1);
            end
         end

         REQ_IF: begin
            // A flush arriving with the response or the timeout drops it.
            if (mem_rvalid || tmo_tc) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (!if_flush) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = mem_rvalid ? mem_rdata : 32'h0;
               end
            end else begin
               tmo_d = tmo_q - TW'(1);
               if (if_flush)
                  state_d = DRAIN;
            end
         end

         REQ_LSU: begin
            if (mem_rvalid) begin
               state_d     = IDLE;
               mem_req_d   = 1'b0;
               lsu_done_d  = 1'b1;
               lsu_rdata_d = mem_rdata;
            end else if (tmo_tc) begin
               state_d     = IDLE;
               mem_req_d   = 1'b0;
               lsu_done_d  = 1'b1;
               lsu_err_d   = 1'b1;
               lsu_rdata_d = 32'h0;
            end else begin
               tmo_d = tmo_q - TW'(1);
            end
         end

         DRAIN: begin
            if (mem_rvalid || tmo_tc) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end else begin
               tmo_d = tmo_q - TW'(1);
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         tmo_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_wstrb_q <= 4'b0000;
         if_done_q   <= 1'b0;
         if_rdata_q  <= 32'h0;
         lsu_done_q  <= 1'b0;
         lsu_rdata_q <= 32'h0;
         lsu_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         if_done_q   <= if_done_d;
         if_rdata_q  <= if_rdata_d;
         lsu_done_q  <= lsu_done_d;
         lsu_rdata_q <= lsu_rdata_d;
         lsu_err_q   <= lsu_err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign if_done   = if_done_q;
   assign if_rdata  = if_rdata_q;
   assign lsu_done  = lsu_done_q;
   assign lsu_rdata = lsu_rdata_q;
   assign lsu_err   = lsu_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple memory responder whose
// read data is the word address XOR a fixed pattern.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        lsu_req;
   logic        lsu_we;
   logic [31:0] lsu_addr;
   logic [1:0]  lsu_width;
   logic [31:0] lsu_wdata;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        lsu_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int resp_delay = 0;
   bit resp_en = 1'b1;
   int wait_cnt = 0;

   localparam logic [31:0] PAT = 32'hC0DE_0000;

   mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_flush   (if_flush),
      .if_done    (if_done),
      .if_rdata   (if_rdata),
      .lsu_req    (lsu_req),
      .lsu_we     (lsu_we),
      .lsu_addr   (lsu_addr),
      .lsu_width  (lsu_width),
      .lsu_wdata  (lsu_wdata),
      .lsu_done   (lsu_done),
      .lsu_rdata  (lsu_rdata),
      .lsu_err    (lsu_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder drives on the falling edge, away from the DUT sampling edge.
   always @(negedge clk) begin
      if (rst || !mem_req) begin
         mem_rvalid = 1'b0;
         wait_cnt   = 0;
      end else if (resp_en && wait_cnt >= resp_delay) begin
         mem_rvalid = 1'b1;
         mem_rdata  = mem_addr ^ PAT;
      end else begin
         mem_rvalid = 1'b0;
         wait_cnt   = wait_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_lsu(input int max_cyc);
      int n = 0;
      while (!lsu_done && n < max_cyc) begin
         tick();
         n++;
      end
      chk("lsu_done_seen", {31'b0, lsu_done}, 32'd1);
   endtask

   task automatic wait_if(input int max_cyc);
      int n = 0;
      while (!if_done && n < max_cyc) begin
         tick();
         n++;
      end
      chk("if_done_seen", {31'b0, if_done}, 32'd1);
   endtask

   task automatic do_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d,
                           input logic [3:0] es, input logic [31:0] ed);
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = a; lsu_width = w; lsu_wdata = d;
      tick();
      chk("st_req",   {31'b0, mem_req}, 32'd1);
      chk("st_we",    {31'b0, mem_we}, 32'd1);
      chk("st_strb",  {28'b0, mem_wstrb}, {28'b0, es});
      chk("st_wdata", mem_wdata, ed);
      chk("st_addr",  mem_addr, a & 32'hFFFF_FFFC);
      wait_lsu(10);
      chk("st_err", {31'b0, lsu_err}, 32'd0);
      lsu_req = 1'b0; lsu_we = 1'b0;
      tick();
   endtask

   logic [31:0] st_a [5] = '{32'h2003, 32'h2002, 32'h2000, 32'h2001, 32'h2004};
   logic [1:0]  st_w [5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
   logic [31:0] st_d [5] = '{32'h0000_00AB, 32'h1234_5678, 32'h0000_BEEF, 32'h1122_3344, 32'hDEAD_BEEF};
   logic [3:0]  st_s [5] = '{4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
   logic [31:0] st_e [5] = '{32'hABAB_ABAB, 32'h5678_5678, 32'hBEEF_BEEF, 32'h4444_4444, 32'hDEAD_BEEF};

   logic [31:0] ma_a [4] = '{32'h2001, 32'h2002, 32'h2000, 32'h2003};
   logic [1:0]  ma_w [4] = '{2'b01, 2'b10, 2'b11, 2'b01};

   initial begin
      int n, guard;
      rst = 1'b0; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
      lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = 32'h0; lsu_width = 2'b10; lsu_wdata = 32'h0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      #1 rst = 1'b1;
      tick(); tick();
      chk("rst_mem_req",  {31'b0, mem_req}, 32'd0);
      chk("rst_if_done",  {31'b0, if_done}, 32'd0);
      chk("rst_lsu_done", {31'b0, lsu_done}, 32'd0);
      chk("rst_wstrb",    {28'b0, mem_wstrb}, 32'd0);
      chk("rst_addr",     mem_addr, 32'd0);
      chk("rst_lsu_rd",   lsu_rdata, 32'd0);
      rst = 1'b0;
      tick();

      // Simultaneous requests: LSU first, IF right after lsu_done.
      if_req = 1'b1; if_addr = 32'h100;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h2000; lsu_width = 2'b10;
      tick();
      chk("arb_lsu_req",  {31'b0, mem_req}, 32'd1);
      chk("arb_lsu_addr", mem_addr, 32'h2000);
      chk("arb_lsu_strb", {28'b0, mem_wstrb}, 32'd0);
      tick();
      chk("arb_lsu_done", {31'b0, lsu_done}, 32'd1);
      chk("arb_lsu_rd",   lsu_rdata, 32'hC0DE_2000);
      chk("arb_lsu_err",  {31'b0, lsu_err}, 32'd0);
      chk("arb_if_nd",    {31'b0, if_done}, 32'd0);
      lsu_req = 1'b0;
      tick();
      chk("arb_if_req",   {31'b0, mem_req}, 32'd1);
      chk("arb_if_addr",  mem_addr, 32'h100);
      chk("arb_lsu_pls",  {31'b0, lsu_done}, 32'd0);
      tick();
      chk("arb_if_done",  {31'b0, if_done}, 32'd1);
      chk("arb_if_rd",    if_rdata, 32'hC0DE_0100);
      if_req = 1'b0;
      tick();
      chk("arb_if_pls",   {31'b0, if_done}, 32'd0);
      chk("arb_lsu_hold", lsu_rdata, 32'hC0DE_2000);

      // Store strobes and lane replication.
      for (int i = 0; i < 5; i++)
         do_store(st_a[i], st_w[i], st_d[i], st_s[i], st_e[i]);

      // Misaligned or illegal accesses: error next cycle, no bus access.
      for (int i = 0; i < 4; i++) begin
         lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = ma_a[i]; lsu_width = ma_w[i];
         tick();
         chk("mis_done", {31'b0, lsu_done}, 32'd1);
         chk("mis_err",  {31'b0, lsu_err}, 32'd1);
         chk("mis_rd",   lsu_rdata, 32'd0);
         chk("mis_req",  {31'b0, mem_req}, 32'd0);
         lsu_req = 1'b0;
         tick();
         chk("mis_req2", {31'b0, mem_req}, 32'd0);
         chk("mis_pls",  {31'b0, lsu_done}, 32'd0);
      end

      // Starvation: back-to-back LSU loads with IF held.
      if_req = 1'b1; if_addr = 32'h300;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h4000; lsu_width = 2'b10;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (lsu_done) n++;
         if (mem_req && mem_addr == 32'h300) break;
      end
      chk("stv_if_addr",  mem_addr, 32'h300);
      chk("stv_lsu_wins", n, 32'd4);
      wait_if(10);
      chk("stv_if_rd", if_rdata, 32'hC0DE_0300);
      if_req = 1'b0;
      tick();
      wait_lsu(10);
      chk("stv_lsu_rd", lsu_rdata, 32'hC0DE_4000);
      lsu_req = 1'b0;
      tick();

      // Flush during REQ_IF, response 3 cycles later.
      resp_delay = 3;
      if_req = 1'b1; if_addr = 32'h500;
      tick();
      chk("fl_req", {31'b0, mem_req}, 32'd1);
      if_flush = 1'b1;
      tick();
      if_flush = 1'b0; if_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("fl_no_done", {31'b0, if_done}, 32'd0);
         chk("fl_hold", {31'b0, mem_req}, (i < 3) ? 32'd1 : 32'd0);
         chk("fl_addr", mem_addr, 32'h500);
         tick();
      end
      chk("fl_no_done2", {31'b0, if_done}, 32'd0);
      resp_delay = 0;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h2008; lsu_width = 2'b10;
      tick();
      chk("fl_lsu_addr", mem_addr, 32'h2008);
      wait_lsu(10);
      chk("fl_lsu_rd",  lsu_rdata, 32'hC0DE_2008);
      chk("fl_lsu_err", {31'b0, lsu_err}, 32'd0);
      lsu_req = 1'b0;
      tick();

      // Timeout: no response at all.
      resp_en = 1'b0;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h6000; lsu_width = 2'b10;
      n = 0; guard = 0;
      while (!lsu_done && guard < 400) begin
         if (mem_req) n++;
         tick();
         guard++;
      end
      chk("tmo_done", {31'b0, lsu_done}, 32'd1);
      chk("tmo_cycles", n, 32'd255);
      chk("tmo_err", {31'b0, lsu_err}, 32'd1);
      chk("tmo_rd", lsu_rdata, 32'd0);
      chk("tmo_req", {31'b0, mem_req}, 32'd0);
      lsu_req = 1'b0;
      tick();

      // Async reset in the middle of a bus request.
      lsu_req = 1'b1; lsu_addr = 32'h7000;
      for (int i = 0; i < 5; i++) tick();
      chk("rst_mid_req", {31'b0, mem_req}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_clr", {31'b0, mem_req}, 32'd0);
      chk("rst_mid_adr", mem_addr, 32'd0);
      lsu_req = 1'b0;
      tick();
      rst = 1'b0;
      resp_en = 1'b1;
      tick();

      lsu_req = 1'b1; lsu_addr = 32'h2010;
      tick();
      wait_lsu(10);
      chk("post_rst_rd", lsu_rdata, 32'hC0DE_2010);
      lsu_req = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
